// File: rtl/fifo_main_if.sv
// fifo_main_if: push/pop handshake, thresholds and status bundle for the main ingress FIFO.
`default_nettype none

interface fifo_main_if #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
);
  logic                  Main_wr;
  logic [DATA_WIDTH-1:0] Main_data_in;
  logic                  Main_rd;
  logic [ADDR_WIDTH:0]   Main_umbral_alto;
  logic [ADDR_WIDTH:0]   Main_umbral_bajo;
  logic [DATA_WIDTH-1:0] Main_data_out;
  logic                  Main_empty;
  logic                  Main_full;
  logic                  Main_almost_full;
  logic                  Main_almost_empty;
  logic                  Main_error;

  modport master (
    output Main_wr, Main_data_in, Main_rd, Main_umbral_alto, Main_umbral_bajo,
    input  Main_data_out, Main_empty, Main_full, Main_almost_full,
           Main_almost_empty, Main_error
  );

  modport slave (
    input  Main_wr, Main_data_in, Main_rd, Main_umbral_alto, Main_umbral_bajo,
    output Main_data_out, Main_empty, Main_full, Main_almost_full,
           Main_almost_empty, Main_error
  );
endinterface

`default_nettype wire

// File: rtl/fifo_main.sv
// fifo_main: 8-entry FWFT ingress FIFO with programmable almost-full/empty
// flags and a sticky overflow/underflow error. Rev 1.0
`default_nettype none

module fifo_main #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  wire logic   clk,
  input  wire logic   reset,
  fifo_main_if.slave  bus
);
  localparam int                  DEPTH      = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_DEPTH    = DEPTH;
  localparam logic [ADDR_WIDTH:0] c_CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE = 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_err;

  logic w_empty;
  logic w_full;
  logic w_rd_ok;
  logic w_push_ok;
  logic w_err_evt;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_DEPTH);
  assign w_rd_ok   = bus.Main_rd & ~w_empty;
  // A pop at full frees the slot the push lands in, so the push is still legal.
  assign w_push_ok = bus.Main_wr & (~w_full | w_rd_ok);
  assign w_err_evt = (bus.Main_wr & w_full & ~w_rd_ok) | (bus.Main_rd & w_empty);

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= bus.Main_data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push_ok, w_rd_ok})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_err_evt) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.Main_data_out     = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.Main_empty        = w_empty;
  assign bus.Main_full         = w_full;
  assign bus.Main_almost_full  = (r_count >= bus.Main_umbral_alto);
  assign bus.Main_almost_empty = (r_count <= bus.Main_umbral_bajo);
  assign bus.Main_error        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_fifo_main.sv
// tb_fifo_main: table-driven plus directed corner-case checks for fifo_main.
`default_nettype none

module tb_fifo_main;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  fifo_main_if #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) bus ();

  fifo_main #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [5:0] din;
    logic [3:0] alto;
    logic [3:0] bajo;
    logic [5:0] dout;
    logic       e;
    logic       f;
    logic       af;
    logic       ae;
    logic       err;
  } vec_t;

  vec_t tbl[$];
  logic [5:0] q[$];

  function automatic vec_t mk(logic wr, logic rd, logic [5:0] din, logic [3:0] alto,
                              logic [3:0] bajo, logic [5:0] dout, logic e, logic f,
                              logic af, logic ae, logic err);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = din; v.alto = alto; v.bajo = bajo;
    v.dout = dout; v.e = e; v.f = f; v.af = af; v.ae = ae; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [5:0] dout, input logic e,
                         input logic f, input logic af, input logic ae, input logic err);
    chk({tag, ".dout"},  {2'b00, bus.Main_data_out},   {2'b00, dout});
    chk({tag, ".empty"}, {7'd0, bus.Main_empty},        {7'd0, e});
    chk({tag, ".full"},  {7'd0, bus.Main_full},         {7'd0, f});
    chk({tag, ".af"},    {7'd0, bus.Main_almost_full},  {7'd0, af});
    chk({tag, ".ae"},    {7'd0, bus.Main_almost_empty}, {7'd0, ae});
    chk({tag, ".err"},   {7'd0, bus.Main_error},        {7'd0, err});
  endtask

  // Drive one cycle of inputs, let one rising edge pass, sample 1ns later.
  task automatic step(input logic wr, input logic rd, input logic [5:0] din);
    @(negedge clk);
    bus.Main_wr      = wr;
    bus.Main_rd      = rd;
    bus.Main_data_in = din;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.Main_wr = 1'b0;
    bus.Main_rd = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    bus.Main_wr          = 1'b0;
    bus.Main_rd          = 1'b0;
    bus.Main_data_in     = 6'h00;
    bus.Main_umbral_alto = 4'd6;
    bus.Main_umbral_bajo = 4'd1;
    reset = 1'b1;

    //           wr rd din    alto bajo dout  e  f  af ae err
    tbl.push_back(mk(1, 0, 6'h01, 6, 1, 6'h01, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 6'h02, 6, 1, 6'h01, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 6'h03, 6, 1, 6'h01, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 6'h04, 6, 1, 6'h01, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 6'h05, 6, 1, 6'h01, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 6'h06, 6, 1, 6'h01, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 6'h07, 6, 1, 6'h01, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 6'h08, 6, 1, 6'h01, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 6'h3F, 6, 1, 6'h01, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 1, 6'h00, 6, 1, 6'h02, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 6'h00, 6, 1, 6'h03, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 6'h00, 6, 1, 6'h04, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 6'h00, 6, 1, 6'h05, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 6'h00, 6, 1, 6'h06, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 6'h00, 6, 1, 6'h07, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 6'h00, 6, 1, 6'h08, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 6'h00, 6, 1, 6'h00, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 6'h00, 0, 0, 6'h00, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 6'h00, 8, 8, 6'h00, 1, 0, 0, 1, 1));

    // Reset state, sampled while reset is still held.
    #3;
    chk_all("reset", 6'h00, 1, 0, 0, 1, 0);
    @(negedge clk);
    reset = 1'b0;

    // Fill, overflow, drain, threshold boundaries.
    foreach (tbl[i]) begin
      bus.Main_umbral_alto = tbl[i].alto;
      bus.Main_umbral_bajo = tbl[i].bajo;
      step(tbl[i].wr, tbl[i].rd, tbl[i].din);
      chk_all($sformatf("vec%0d", i), tbl[i].dout, tbl[i].e, tbl[i].f,
              tbl[i].af, tbl[i].ae, tbl[i].err);
    end
    bus.Main_umbral_alto = 4'd6;
    bus.Main_umbral_bajo = 4'd1;

    // Simultaneous push+pop at full.
    do_reset();
    for (int k = 1; k <= 8; k++) step(1'b1, 1'b0, 6'(k));
    chk("full_pre.full", {7'd0, bus.Main_full}, 8'd1);
    chk("full_pre.head", {2'b00, bus.Main_data_out}, 8'h01);
    step(1'b1, 1'b1, 6'h2A);
    chk_all("full_rw", 6'h02, 0, 1, 1, 0, 0);
    for (int k = 3; k <= 8; k++) begin
      step(1'b0, 1'b1, 6'h00);
      chk($sformatf("full_rw.pop%0d", k), {2'b00, bus.Main_data_out}, 8'(k));
    end
    step(1'b0, 1'b1, 6'h00);
    chk("full_rw.tail", {2'b00, bus.Main_data_out}, 8'h2A);
    step(1'b0, 1'b1, 6'h00);
    chk_all("full_rw.drained", 6'h00, 1, 0, 0, 1, 0);

    // Underflow combined with push into empty.
    do_reset();
    step(1'b1, 1'b1, 6'h15);
    chk_all("uf_push", 6'h15, 0, 0, 0, 1, 1);

    // Wrap-around: 20 push+pop cycles, order checked against a queue model.
    q.delete();
    q.push_back(6'h15);
    step(1'b1, 1'b0, 6'h2C);
    q.push_back(6'h2C);
    for (int i = 0; i < 20; i++) begin
      logic [5:0] d;
      d = 6'((i * 7 + 3) & 6'h3F);
      step(1'b1, 1'b1, d);
      void'(q.pop_front());
      q.push_back(d);
      chk($sformatf("wrap%0d", i), {2'b00, bus.Main_data_out}, {2'b00, q[0]});
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 6'(6'h30 + i));
    step(1'b0, 1'b0, 6'h00);
    chk_all("cnt5", q[0], 0, 0, 0, 0, 1);

    // Asynchronous reset between edges.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk_all("async_rst", 6'h00, 1, 0, 0, 1, 0);
    #1;
    reset = 1'b0;
    step(1'b1, 1'b0, 6'h1B);
    chk_all("post_rst", 6'h1B, 0, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
